// File: rtl/dmux_stream_nway_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmux_stream_nway_if                                                        |
// | Producer-side and consumer-side handshake bundle for dmux_stream_nway.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dmux_stream_nway_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_OUT = 8,
   parameter int SEL_W   = 3
);
   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           in_data;
   logic [SEL_W-1:0]           in_sel;
   logic                       in_bcast;
   logic [NUM_OUT-1:0]         out_valid;
   logic [NUM_OUT-1:0]         out_ready;
   logic [NUM_OUT*WIDTH-1:0]   out_data;
   logic                       drop;

   // The demultiplexer itself sits on the slave side.
   modport slave (
      input  in_valid, in_data, in_sel, in_bcast, out_ready,
      output in_ready, out_valid, out_data, drop
   );

   modport master (
      output in_valid, in_data, in_sel, in_bcast, out_ready,
      input  in_ready, out_valid, out_data, drop
   );
endinterface
`default_nettype wire

// File: rtl/dmux_stream_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmux_stream_nway                                                           |
// | Registered 1-to-NUM_OUT stream demux with unicast/broadcast steering.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmux_stream_nway #(
   parameter int WIDTH   = 8,
   parameter int NUM_OUT = 8,
   parameter int SEL_W   = 3
) (
   input  wire logic          clk,
   input  wire logic          rst,
   dmux_stream_nway_if.slave  bus
);
   logic [SEL_W-1:0]   w_sel;
   logic [NUM_OUT-1:0] w_full;
   logic [NUM_OUT-1:0] w_free;
   logic [NUM_OUT-1:0] w_sel_hit;
   logic [NUM_OUT-1:0] w_target;
   logic               w_sel_in_range;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_drop_nxt;
   logic               r_drop;

   assign w_sel          = bus.in_sel;
   assign w_free         = ~w_full | bus.out_ready;
   assign w_sel_in_range = (32'(w_sel) < NUM_OUT);

   // Out-of-range unicast is always accepted so it can be discarded.
   always_comb begin
      w_in_ready = 1'b1;
      if (bus.in_bcast) begin
         w_in_ready = &w_free;
      end else if (w_sel_in_range) begin
         w_in_ready = |(w_free & w_sel_hit);
      end
   end

   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_drop_nxt = w_accept & ~bus.in_bcast & ~w_sel_in_range;

   always_comb begin
      w_target = '0;
      if (w_accept) begin
         w_target = bus.in_bcast ? {NUM_OUT{1'b1}} : w_sel_hit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop <= 1'b0;
      end else begin
         r_drop <= w_drop_nxt;
      end
   end

   generate
      for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
         logic             r_full;
         logic [WIDTH-1:0] r_data;

         assign w_sel_hit[k] = (32'(w_sel) == k);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_full <= 1'b0;
               r_data <= '0;
            end else if (w_target[k]) begin
               r_full <= 1'b1;
               r_data <= bus.in_data;
            end else if (bus.out_ready[k]) begin
               r_full <= 1'b0;
            end
         end

         assign w_full[k]                        = r_full;
         assign bus.out_data[k*WIDTH +: WIDTH]   = r_data;
      end
   endgenerate

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_full;
   assign bus.drop      = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_dmux_stream_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmux_stream_nway                                                        |
// | Self-checking bench: directed scenarios on 8- and 6-channel instances.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dmux_stream_nway;
   typedef struct {
      int         ch;
      logic [7:0] data;
   } sb_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sb_t        exp_q[$];
   logic [7:0] mq[6][$];

   dmux_stream_nway_if #(.WIDTH(8), .NUM_OUT(8), .SEL_W(3)) b8();
   dmux_stream_nway_if #(.WIDTH(8), .NUM_OUT(6), .SEL_W(3)) b6();

   dmux_stream_nway #(.WIDTH(8), .NUM_OUT(8), .SEL_W(3)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (b8.slave)
   );

   dmux_stream_nway #(.WIDTH(8), .NUM_OUT(6), .SEL_W(3)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (b6.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle8();
      b8.in_valid = 1'b0;
      b8.in_bcast = 1'b0;
      b8.in_sel   = '0;
      b8.in_data  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle8();
      b8.out_ready = '0;
      b6.in_valid = 1'b0; b6.in_bcast = 1'b0; b6.in_sel = '0; b6.in_data = '0;
      b6.out_ready = '0;
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'h00 || b8.out_data !== 64'h0 || b8.drop !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%h data=%h drop=%b required 00/0/0", b8.out_valid, b8.out_data, b8.drop);
      end
      rst = 1'b0;
      @(negedge clk);
      b8.in_valid = 1'b1; b8.in_sel = 3'd2; b8.in_data = 8'h12;
      @(negedge clk);
      b8.in_sel = 3'd5; b8.in_data = 8'h15;
      @(negedge clk);
      idle8();
      checks++;
      if (b8.out_valid !== 8'h24) begin
         errors++;
         $display("FAIL reset_fill: valid=%h required 24", b8.out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (b8.out_valid !== 8'h00 || b8.drop !== 1'b0 || b8.out_data !== 64'h0) begin
         errors++;
         $display("FAIL reset_async: valid=%h drop=%b data=%h required 00/0/0", b8.out_valid, b8.drop, b8.out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 8; s++) begin
         b8.in_sel = 3'(s);
         #1;
         checks++;
         if (b8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready sel=%0d: in_ready=%b required 1", s, b8.in_ready);
         end
      end
      idle8();
   endtask

   task automatic test_unicast_sweep();
      sb_t e;
      b8.out_ready = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (b8.out_valid !== (8'd1 << e.ch) || b8.out_data[e.ch*8 +: 8] !== e.data) begin
               errors++;
               $display("FAIL sweep ch%0d: valid=%h data=%h required %h/%h",
                        e.ch, b8.out_valid, b8.out_data[e.ch*8 +: 8], 8'd1 << e.ch, e.data);
            end
         end
         if (k < 8) begin
            b8.in_valid = 1'b1;
            b8.in_sel   = 3'(k);
            b8.in_data  = 8'(8'hA0 + k);
            #1;
            checks++;
            if (b8.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL sweep_ready k=%0d: in_ready=%b required 1", k, b8.in_ready);
            end
            exp_q.push_back('{ch: k, data: 8'(8'hA0 + k)});
         end else begin
            idle8();
         end
      end
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'h00) begin
         errors++;
         $display("FAIL sweep_drain: valid=%h required 00", b8.out_valid);
      end
   endtask

   task automatic test_backpressure();
      b8.out_ready = 8'hF7;
      b8.in_valid = 1'b1; b8.in_sel = 3'd3; b8.in_data = 8'h11;
      #1;
      checks++;
      if (b8.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first_ready: in_ready=%b required 1", b8.in_ready);
      end
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'h08 || b8.out_data[3*8 +: 8] !== 8'h11) begin
         errors++;
         $display("FAIL bp_held: valid=%h d3=%h required 08/11", b8.out_valid, b8.out_data[3*8 +: 8]);
      end
      b8.in_data = 8'h22;
      #1;
      checks++;
      if (b8.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_blocked: in_ready=%b required 0", b8.in_ready);
      end
      @(negedge clk);
      b8.in_sel = 3'd4; b8.in_data = 8'h33;
      #1;
      checks++;
      if (b8.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_other_ready: in_ready=%b required 1", b8.in_ready);
      end
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'h18 || b8.out_data[3*8 +: 8] !== 8'h11 || b8.out_data[4*8 +: 8] !== 8'h33) begin
         errors++;
         $display("FAIL bp_isolation: valid=%h d3=%h d4=%h required 18/11/33",
                  b8.out_valid, b8.out_data[3*8 +: 8], b8.out_data[4*8 +: 8]);
      end
      b8.out_ready = 8'hFF;
      b8.in_sel = 3'd3; b8.in_data = 8'h22;
      #1;
      checks++;
      if (b8.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: in_ready=%b required 1", b8.in_ready);
      end
      @(negedge clk);
      idle8();
      checks++;
      if (b8.out_valid !== 8'h08 || b8.out_data[3*8 +: 8] !== 8'h22) begin
         errors++;
         $display("FAIL bp_same_cycle: valid=%h d3=%h required 08/22", b8.out_valid, b8.out_data[3*8 +: 8]);
      end
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'h00) begin
         errors++;
         $display("FAIL bp_drain: valid=%h required 00", b8.out_valid);
      end
   endtask

   task automatic test_broadcast();
      b8.out_ready = 8'h00;
      b8.in_valid = 1'b1; b8.in_bcast = 1'b1; b8.in_data = 8'h5A;
      #1;
      checks++;
      if (b8.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bcast_ready: in_ready=%b required 1", b8.in_ready);
      end
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'hFF || b8.out_data !== {8{8'h5A}}) begin
         errors++;
         $display("FAIL bcast_deliver: valid=%h data=%h required FF/%h", b8.out_valid, b8.out_data, {8{8'h5A}});
      end
      b8.out_ready = 8'hBF;
      b8.in_data = 8'h6B;
      #1;
      checks++;
      if (b8.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bcast_blocked: in_ready=%b required 0", b8.in_ready);
      end
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'h40 || b8.out_data[6*8 +: 8] !== 8'h5A || b8.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bcast_no_partial: valid=%h d6=%h rdy=%b required 40/5A/0",
                  b8.out_valid, b8.out_data[6*8 +: 8], b8.in_ready);
      end
      b8.out_ready = 8'hFF;
      #1;
      checks++;
      if (b8.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bcast_unblock: in_ready=%b required 1", b8.in_ready);
      end
      @(negedge clk);
      idle8();
      checks++;
      if (b8.out_valid !== 8'hFF || b8.out_data !== {8{8'h6B}}) begin
         errors++;
         $display("FAIL bcast_second: valid=%h data=%h required FF/%h", b8.out_valid, b8.out_data, {8{8'h6B}});
      end
      @(negedge clk);
      checks++;
      if (b8.out_valid !== 8'h00) begin
         errors++;
         $display("FAIL bcast_drain: valid=%h required 00", b8.out_valid);
      end
   endtask

   task automatic test_out_of_range();
      @(negedge clk);
      b6.out_ready = 6'h00;
      b6.in_valid = 1'b1; b6.in_sel = 3'd1; b6.in_data = 8'h77;
      @(negedge clk);
      checks++;
      if (b6.out_valid !== 6'h02 || b6.drop !== 1'b0) begin
         errors++;
         $display("FAIL oor_setup: valid=%h drop=%b required 02/0", b6.out_valid, b6.drop);
      end
      b6.in_sel = 3'd7; b6.in_data = 8'hEE;
      #1;
      checks++;
      if (b6.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL oor_ready: in_ready=%b required 1", b6.in_ready);
      end
      @(negedge clk);
      b6.in_valid = 1'b0;
      checks++;
      if (b6.drop !== 1'b1 || b6.out_valid !== 6'h02 || b6.out_data[1*8 +: 8] !== 8'h77) begin
         errors++;
         $display("FAIL oor_drop: drop=%b valid=%h d1=%h required 1/02/77",
                  b6.drop, b6.out_valid, b6.out_data[1*8 +: 8]);
      end
      @(negedge clk);
      checks++;
      if (b6.drop !== 1'b0) begin
         errors++;
         $display("FAIL oor_pulse: drop=%b required 0", b6.drop);
      end
      b6.out_ready = 6'h3F;
      @(negedge clk);
      checks++;
      if (b6.out_valid !== 6'h00) begin
         errors++;
         $display("FAIL oor_drain: valid=%h required 00", b6.out_valid);
      end
   endtask

   task automatic test_random_soak();
      logic       exp_drop;
      logic       exp_v;
      logic       exp_rdy;
      logic [5:0] free;
      exp_drop = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         for (int k = 0; k < 6; k++) begin
            exp_v = (mq[k].size() != 0);
            checks++;
            if (b6.out_valid[k] !== exp_v || (exp_v && b6.out_data[k*8 +: 8] !== mq[k][0])) begin
               errors++;
               $display("FAIL soak_out c=%0d ch%0d: valid=%b data=%h required %b/%h",
                        c, k, b6.out_valid[k], b6.out_data[k*8 +: 8], exp_v, exp_v ? mq[k][0] : 8'h00);
            end
         end
         checks++;
         if (b6.drop !== exp_drop) begin
            errors++;
            $display("FAIL soak_drop c=%0d: drop=%b required %b", c, b6.drop, exp_drop);
         end
         b6.in_valid  = ($urandom_range(0, 1) == 1);
         b6.in_bcast  = ($urandom_range(0, 7) == 0);
         b6.in_sel    = 3'($urandom_range(0, 7));
         b6.in_data   = 8'($urandom);
         for (int k = 0; k < 6; k++) b6.out_ready[k] = ($urandom_range(0, 9) < 7);
         #1;
         for (int k = 0; k < 6; k++) free[k] = (mq[k].size() == 0) || b6.out_ready[k];
         if (b6.in_bcast) exp_rdy = &free;
         else if (b6.in_sel < 3'd6) exp_rdy = free[b6.in_sel];
         else exp_rdy = 1'b1;
         checks++;
         if (b6.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL soak_ready c=%0d: in_ready=%b required %b", c, b6.in_ready, exp_rdy);
         end
         for (int k = 0; k < 6; k++) begin
            if (mq[k].size() != 0 && b6.out_ready[k]) void'(mq[k].pop_front());
         end
         exp_drop = 1'b0;
         if (b6.in_valid && exp_rdy) begin
            if (b6.in_bcast) begin
               for (int k = 0; k < 6; k++) mq[k].push_back(b6.in_data);
            end else if (b6.in_sel < 3'd6) begin
               mq[b6.in_sel].push_back(b6.in_data);
            end else begin
               exp_drop = 1'b1;
            end
         end
      end
      @(negedge clk);
      b6.in_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unicast_sweep();
      test_backpressure();
      test_broadcast();
      test_out_of_range();
      test_random_soak();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
